// File: rtl/midi_timer_pkg.sv
// Register map, control/status bit positions and small helpers shared by midi_multi_timer.
package midi_timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_OVR      = 3'd7;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  localparam int OVR_W = 16;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (v == {OVR_W{1'b1}}) ? v : v + OVR_W'(1);
  endfunction

endpackage

// File: rtl/midi_timer_channel.sv
// One timer channel: prescaler, down-counter, run control, TO/IRQ and snapshot; rd_word is
// combinational from registers. Overrun counter present only with MIDI_TIMER_OVERRUN_EN.
module midi_timer_channel
  import midi_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 8,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  reg_sel,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_word,
  output logic        irq
);

  localparam int HI_W = CNT_W - 16;

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] snapshot;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pc;
  logic [3:0]       control;
  logic             running;
  logic             to;
  logic             force_reload;
  logic             zero_d;

  logic wr_status, wr_control, wr_period_l, wr_period_h, wr_snap, wr_prescale;
  logic start_wr, stop_wr, tick, cnt_zero, to_event, oneshot_done;

  assign wr_status   = wr_en && (reg_sel == REG_STATUS);
  assign wr_control  = wr_en && (reg_sel == REG_CONTROL);
  assign wr_period_l = wr_en && (reg_sel == REG_PERIOD_L);
  assign wr_period_h = wr_en && (reg_sel == REG_PERIOD_H);
  assign wr_snap     = wr_en && ((reg_sel == REG_SNAP_L) || (reg_sel == REG_SNAP_H));
  assign wr_prescale = wr_en && (reg_sel == REG_PRESCALE);

  assign start_wr     = wr_control && wr_data[CTL_START];
  assign stop_wr      = wr_control && wr_data[CTL_STOP];
  assign tick         = (pc == '0);
  assign cnt_zero     = (counter == '0);
  // Edge rather than level, so a zero period in CONT mode raises TO only once.
  assign to_event     = cnt_zero && !zero_d;
  assign oneshot_done = cnt_zero && !control[CTL_CONT];

  assign irq = to && control[CTL_ITO];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter      <= CNT_W'(RESET_PERIOD);
      period       <= CNT_W'(RESET_PERIOD);
      snapshot     <= '0;
      prescale     <= '0;
      pc           <= '0;
      control      <= '0;
      running      <= 1'b0;
      to           <= 1'b0;
      force_reload <= 1'b0;
      zero_d       <= 1'b0;
    end else begin
      force_reload <= wr_period_l || wr_period_h;
      zero_d       <= cnt_zero;

      if (wr_control)  control <= wr_data[3:0];
      if (wr_period_l) period[15:0] <= wr_data;
      if (wr_period_h) period[CNT_W-1:16] <= wr_data[HI_W-1:0];
      if (wr_prescale) prescale <= wr_data[PRE_W-1:0];
      if (wr_snap)     snapshot <= counter;

      if (start_wr || force_reload || tick) pc <= prescale;
      else                                  pc <= pc - PRE_W'(1);

      if (force_reload)
        counter <= period;
      else if (running && tick)
        counter <= cnt_zero ? period : counter - CNT_W'(1);

      // START beats every stop source, including a one-shot reaching zero.
      if (start_wr)
        running <= 1'b1;
      else if (stop_wr || force_reload || oneshot_done)
        running <= 1'b0;

      if (wr_status)     to <= 1'b0;
      else if (to_event) to <= 1'b1;
    end
  end

`ifdef MIDI_TIMER_OVERRUN_EN
  logic [OVR_W-1:0] ovr_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              ovr_cnt <= '0;
    else if (wr_status)        ovr_cnt <= '0;
    else if (to_event && to)   ovr_cnt <= sat_inc(ovr_cnt);
  end
`endif

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_word[ST_TO]  = to;
        rd_word[ST_RUN] = running;
      end
      REG_CONTROL:  rd_word[3:0]       = control;
      REG_PERIOD_L: rd_word            = period[15:0];
      REG_PERIOD_H: rd_word[HI_W-1:0]  = period[CNT_W-1:16];
      REG_SNAP_L:   rd_word            = snapshot[15:0];
      REG_SNAP_H:   rd_word[HI_W-1:0]  = snapshot[CNT_W-1:16];
      REG_PRESCALE: rd_word[PRE_W-1:0] = prescale;
`ifdef MIDI_TIMER_OVERRUN_EN
      REG_OVR:      rd_word            = ovr_cnt;
`endif
      default:      rd_word            = '0;
    endcase
  end

endmodule

// File: rtl/midi_multi_timer.sv
// NUM_CH-channel interval timer on a 16-bit Avalon-MM slave; readdata one cycle after address,
// no wait states. Build with MIDI_TIMER_OVERRUN_EN for per-channel overrun counters at reg 7.
module midi_multi_timer
  import midi_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999,
  parameter int          PRE_W        = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_CH)+3-1:0] address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [15:0]                 writedata,
  output logic [15:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec
);

  localparam int AW = $clog2(NUM_CH) + 3;
  // One spare bit keeps the channel field non-empty when NUM_CH is 1.
  localparam int SW = AW - 2;

  logic [SW-1:0]     ch_sel;
  logic              bus_wr;
  logic [NUM_CH-1:0] ch_wr;
  logic [15:0]       rd_words [NUM_CH];
  logic [15:0]       rd_next;

  assign ch_sel = SW'(address >> 3);
  assign bus_wr = chipselect && !write_n;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign ch_wr[n] = bus_wr && (ch_sel == SW'(n));

    midi_timer_channel #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (ch_wr[n]),
      .reg_sel (address[2:0]),
      .wr_data (writedata),
      .rd_word (rd_words[n]),
      .irq     (irq_vec[n])
    );
  end

  // Channel indices past NUM_CH match nothing and fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sel == SW'(i)) rd_next = rd_words[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |irq_vec;

endmodule
